pg_multi_ctrl: RTL and testbench
================================

PG_MULTI_CTRL -- requirements
Module: pg_multi_ctrl

Interface
REQ-001 Parameter N_DOM, default 2: number of independent power domains controlled.
REQ-002 Parameter CNT_W, default 18: width of the settle counter and of reference_count.
REQ-003 Parameter HOLD_CYC, default 2: extra hold cycles added after each ISO/CG/SAVE/RESTORE phase (range 0..15).
REQ-004 Parameter TMO_CYC, default 1024: switch-ack timeout limit in cycles (range 2..2^CNT_W-1).
REQ-005 ck  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  N_DOM  per-domain run request; 1=keep or bring domain on, 0=power it down.
REQ-008 sw_ack  in  N_DOM  per-domain power-switch feedback; 1=switches closed, 0=open.
REQ-009 reference_count  in  CNT_W  shared rail-settle count.
REQ-010 err_clr  in  N_DOM  per-domain clear of the sticky err flag.
REQ-011 status  out  N_DOM  1=domain logically on.
REQ-012 en_iso  out  N_DOM  1=isolation active.
REQ-013 rtn  out  N_DOM  1=state retention active.
REQ-014 en_pw_sw  out  N_DOM  1=power switches commanded on.
REQ-015 en_cg  out  N_DOM  0=clock gated, 1=clock running.
REQ-016 busy  out  N_DOM  1=sequence in progress.
REQ-017 err  out  N_DOM  sticky ack-timeout flag.

Function
REQ-018 Each domain SHALL have one fully independent FSM with its own CNT_W-bit counter; domains SHALL NOT interact.
REQ-019 States SHALL be IDLE_ON, ISO_ON, CG_ON, SAVE, SW_OFF, WAIT_OFF_ACK, WAIT_OFF_CNT, IDLE_OFF, SW_ON, WAIT_ON_ACK, WAIT_ON_CNT, RESTORE, CG_OFF, ISO_OFF.
REQ-020 Transitions: IDLE_ON->ISO_ON when en=0; IDLE_OFF->SW_ON when en=1; SW_OFF->WAIT_OFF_ACK and SW_ON->WAIT_ON_ACK after 1 cycle; the fixed sequences are ISO_ON->CG_ON->SAVE->SW_OFF and RESTORE->CG_OFF->ISO_OFF->IDLE_ON.
REQ-021 ISO_ON, CG_ON, SAVE, RESTORE, CG_OFF and ISO_OFF SHALL each last exactly HOLD_CYC+1 cycles, timed by the counter.
REQ-022 WAIT_OFF_ACK SHALL exit to WAIT_OFF_CNT on sw_ack=0; WAIT_ON_ACK SHALL exit to WAIT_ON_CNT on sw_ack=1.
REQ-023 WAIT_OFF_CNT->IDLE_OFF and WAIT_ON_CNT->RESTORE SHALL occur when count==reference_count, i.e. after reference_count+1 cycles; reference_count SHALL be sampled each cycle.
REQ-024 The counter SHALL clear to 0 on every state change and increment otherwise, saturating at all-ones.
REQ-025 Abort: en=1 in ISO_ON SHALL go to ISO_OFF, and en=1 in CG_ON SHALL go to CG_OFF, on the next edge; from SAVE onward, en SHALL be ignored until IDLE_OFF is reached.
REQ-026 en=0 sampled during RESTORE..ISO_OFF SHALL be ignored; power-down restarts from IDLE_ON.
REQ-027 Outputs SHALL be Moore-decoded from the state register only.
REQ-028 Output decode:
- status=0 in IDLE_OFF..RESTORE, else 1.
- en_iso=1 in ISO_ON..CG_OFF, else 0.
- en_cg=0 in CG_ON..RESTORE, else 1.
- rtn=1 in SAVE..WAIT_ON_CNT, else 0.
- en_pw_sw=0 in SW_OFF..IDLE_OFF, else 1.
- busy=0 only in IDLE_ON and IDLE_OFF.
REQ-029 err SHALL clear on err_clr=1; a simultaneous set SHALL win over err_clr.

Reset
REQ-030 On rst, every domain SHALL enter IDLE_ON with count=0, giving status=1, en_iso=0, rtn=0, en_pw_sw=1, en_cg=1, busy=0, err=0; rst mid-sequence SHALL abort to IDLE_ON immediately.

Configuration
REQ-031 With PG_ACK_TIMEOUT_EN defined, a WAIT_*_ACK state whose count reaches TMO_CYC-1 without the expected ack SHALL set err and proceed to the following WAIT_*_CNT state.
REQ-032 Without PG_ACK_TIMEOUT_EN, the FSM SHALL wait for the ack indefinitely, and err SHALL be tied to 0.

Structure
REQ-033 Package pg_pkg SHALL hold the state enum (5-bit encoding) and the default parameter constants.
REQ-034 Sub-module pg_domain_fsm SHALL implement one domain; the top SHALL instantiate it N_DOM times via generate.

Verification
REQ-035 HOLD_CYC=2, ref=3, en[0] 1->0, sw_ack follows en_pw_sw after 2 cycles -> IDLE_OFF reached with status=0, rtn=1, en_pw_sw=0; en_cg falls 3 cycles after en_iso rises.
REQ-036 Wake from IDLE_OFF with ref=3, ack after 2 cycles -> RESTORE entered 4 cycles after ack; rtn falls before en_cg rises; IDLE_ON has all reset values.
REQ-037 en 1->0, then en=1 during CG_ON -> CG_OFF then ISO_OFF then IDLE_ON; rtn never 1, en_pw_sw never 0.
REQ-038 PG_ACK_TIMEOUT_EN defined, TMO_CYC=8, sw_ack stuck at 1 -> err=1 after 8 cycles in WAIT_OFF_ACK and IDLE_OFF still reached; err_clr pulse -> err=0.
REQ-039 N_DOM=2: domain 0 powers down while domain 1 stays on -> domain 1 outputs unchanged; rst asserted in WAIT_ON_CNT -> all domains at reset values.

Source files
------------

// File: rtl/pg_pkg.sv
// -----------------------------------------------------------------------------
// pg_pkg
// Shared types and defaults for the multi-domain power-gating controller.
//   pg_state_e : per-domain sequencer state (5-bit encoding). The states are
//                listed in the order a domain walks through them: the
//                power-down leg, then the wake leg, which wraps back to IDLE_ON.
//   pg_out_t   : the Moore outputs of one domain.
//   pg_decode  : state -> outputs decode.
// -----------------------------------------------------------------------------
package pg_pkg;

    localparam int PG_N_DOM_DEF    = 2;
    localparam int PG_CNT_W_DEF    = 18;
    localparam int PG_HOLD_CYC_DEF = 2;
    localparam int PG_TMO_CYC_DEF  = 1024;

    typedef enum logic [4:0] {
        ST_IDLE_ON      = 5'd0,
        ST_ISO_ON       = 5'd1,
        ST_CG_ON        = 5'd2,
        ST_SAVE         = 5'd3,
        ST_SW_OFF       = 5'd4,
        ST_WAIT_OFF_ACK = 5'd5,
        ST_WAIT_OFF_CNT = 5'd6,
        ST_IDLE_OFF     = 5'd7,
        ST_SW_ON        = 5'd8,
        ST_WAIT_ON_ACK  = 5'd9,
        ST_WAIT_ON_CNT  = 5'd10,
        ST_RESTORE      = 5'd11,
        ST_CG_OFF       = 5'd12,
        ST_ISO_OFF      = 5'd13
    } pg_state_e;

    typedef struct packed {
        logic status;
        logic en_iso;
        logic rtn;
        logic en_pw_sw;
        logic en_cg;
        logic busy;
    } pg_out_t;

    // Start from the fully-on values and override what each state changes.
    function automatic pg_out_t pg_decode(input pg_state_e st);
        pg_out_t o;
        o.status   = 1'b1;
        o.en_iso   = 1'b0;
        o.rtn      = 1'b0;
        o.en_pw_sw = 1'b1;
        o.en_cg    = 1'b1;
        o.busy     = 1'b1;
        case (st)
            ST_IDLE_ON: o.busy = 1'b0;
            ST_ISO_ON:  o.en_iso = 1'b1;
            ST_CG_ON: begin
                o.en_iso = 1'b1;
                o.en_cg  = 1'b0;
            end
            ST_SAVE: begin
                o.en_iso = 1'b1;
                o.en_cg  = 1'b0;
                o.rtn    = 1'b1;
            end
            ST_SW_OFF, ST_WAIT_OFF_ACK, ST_WAIT_OFF_CNT: begin
                o.en_iso   = 1'b1;
                o.en_cg    = 1'b0;
                o.rtn      = 1'b1;
                o.en_pw_sw = 1'b0;
            end
            ST_IDLE_OFF: begin
                o.status   = 1'b0;
                o.en_iso   = 1'b1;
                o.en_cg    = 1'b0;
                o.rtn      = 1'b1;
                o.en_pw_sw = 1'b0;
                o.busy     = 1'b0;
            end
            ST_SW_ON, ST_WAIT_ON_ACK, ST_WAIT_ON_CNT: begin
                o.status = 1'b0;
                o.en_iso = 1'b1;
                o.en_cg  = 1'b0;
                o.rtn    = 1'b1;
            end
            ST_RESTORE: begin
                o.status = 1'b0;
                o.en_iso = 1'b1;
                o.en_cg  = 1'b0;
            end
            ST_CG_OFF: o.en_iso = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pg_domain_fsm.sv
// -----------------------------------------------------------------------------
// pg_domain_fsm
// Power-gating sequencer for a single domain, with its own settle counter.
// Optional feature macro: PG_ACK_TIMEOUT_EN (switch-ack timeout + sticky err).
// Ports:
//   ck, rst             clock, async active-high reset
//   i_en                1 = keep/bring domain on, 0 = power it down
//   i_sw_ack            power-switch feedback, 1 = closed
//   i_reference_count   rail-settle count, sampled every cycle
//   i_err_clr           clear for the sticky err flag
//   o_status .. o_busy  Moore-decoded sequence outputs
//   o_err               sticky ack-timeout flag (0 when timeout is not built)
// -----------------------------------------------------------------------------
module pg_domain_fsm
    import pg_pkg::*;
#(
    parameter int CNT_W    = PG_CNT_W_DEF,
    parameter int HOLD_CYC = PG_HOLD_CYC_DEF,
    parameter int TMO_CYC  = PG_TMO_CYC_DEF
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sw_ack,
    input  logic [CNT_W-1:0] i_reference_count,
    input  logic             i_err_clr,
    output logic             o_status,
    output logic             o_en_iso,
    output logic             o_rtn,
    output logic             o_en_pw_sw,
    output logic             o_en_cg,
    output logic             o_busy,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);

    pg_state_e        r_state;
    pg_state_e        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hold_done;
    logic             w_ref_hit;
    logic             w_tmo_hit;
    logic             w_tmo_evt;
    pg_out_t          w_out;

    // A phase that starts at count 0 and leaves when count==N lasts N+1 cycles.
    assign w_hold_done = (r_cnt == HOLD_LAST);
    assign w_ref_hit   = (r_cnt == i_reference_count);
    assign w_tmo_hit   = (r_cnt == TMO_LAST);

`ifdef PG_ACK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    logic r_err;

    // A timeout in the same cycle as a clear leaves the flag set.
    always_ff @(posedge ck or posedge rst) begin
        if (rst)             r_err <= 1'b0;
        else if (w_tmo_evt)  r_err <= 1'b1;
        else if (i_err_clr)  r_err <= 1'b0;
    end
    assign o_err = r_err;
`else
    localparam bit TMO_EN = 1'b0;
    logic w_unused;
    assign w_unused = ^{i_err_clr, w_tmo_evt};
    assign o_err    = 1'b0;
`endif

    // State register and settle counter; the counter restarts on every
    // state change and saturates instead of wrapping.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE_ON;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Next-state logic. Only ISO_ON and CG_ON honour a late en=1; once SAVE
    // is reached the power-down runs to IDLE_OFF, and the wake leg always
    // completes to IDLE_ON.
    always_comb begin
        // NOTE: defaults before the case keep this purely combinational (no latches).
        w_next    = r_state;
        w_tmo_evt = 1'b0;
        case (r_state)
            ST_IDLE_ON:  if (!i_en) w_next = ST_ISO_ON;
            ST_ISO_ON: begin
                if (i_en)             w_next = ST_ISO_OFF;
                else if (w_hold_done) w_next = ST_CG_ON;
            end
            ST_CG_ON: begin
                if (i_en)             w_next = ST_CG_OFF;
                else if (w_hold_done) w_next = ST_SAVE;
            end
            ST_SAVE:     if (w_hold_done) w_next = ST_SW_OFF;
            ST_SW_OFF:   w_next = ST_WAIT_OFF_ACK;
            ST_WAIT_OFF_ACK: begin
                if (!i_sw_ack) begin
                    w_next = ST_WAIT_OFF_CNT;
                end else if (TMO_EN && w_tmo_hit) begin
                    w_next    = ST_WAIT_OFF_CNT;
                    w_tmo_evt = 1'b1;
                end
            end
            ST_WAIT_OFF_CNT: if (w_ref_hit) w_next = ST_IDLE_OFF;
            ST_IDLE_OFF:     if (i_en) w_next = ST_SW_ON;
            ST_SW_ON:        w_next = ST_WAIT_ON_ACK;
            ST_WAIT_ON_ACK: begin
                if (i_sw_ack) begin
                    w_next = ST_WAIT_ON_CNT;
                end else if (TMO_EN && w_tmo_hit) begin
                    w_next    = ST_WAIT_ON_CNT;
                    w_tmo_evt = 1'b1;
                end
            end
            ST_WAIT_ON_CNT:  if (w_ref_hit) w_next = ST_RESTORE;
            ST_RESTORE:      if (w_hold_done) w_next = ST_CG_OFF;
            ST_CG_OFF:       if (w_hold_done) w_next = ST_ISO_OFF;
            ST_ISO_OFF:      if (w_hold_done) w_next = ST_IDLE_ON;
            default:         w_next = ST_IDLE_ON;
        endcase
    end

    // Moore outputs from the state register only.
    always_comb begin
        w_out = pg_decode(r_state);
    end

    assign o_status   = w_out.status;
    assign o_en_iso   = w_out.en_iso;
    assign o_rtn      = w_out.rtn;
    assign o_en_pw_sw = w_out.en_pw_sw;
    assign o_en_cg    = w_out.en_cg;
    assign o_busy     = w_out.busy;

endmodule

// File: rtl/pg_multi_ctrl.sv
// -----------------------------------------------------------------------------
// pg_multi_ctrl
// N_DOM independent power-gating sequencers sharing one clock, reset and
// rail-settle count. Each bit of the vector ports belongs to one domain.
// Optional feature macro: PG_ACK_TIMEOUT_EN (switch-ack timeout + sticky err).
// Ports:
//   ck, rst           clock, async active-high reset
//   en                per-domain run request
//   sw_ack            per-domain power-switch feedback
//   reference_count   shared rail-settle count
//   err_clr           per-domain sticky-err clear
//   status, en_iso, rtn, en_pw_sw, en_cg, busy, err   per-domain outputs
// -----------------------------------------------------------------------------
module pg_multi_ctrl
    import pg_pkg::*;
#(
    parameter int N_DOM    = PG_N_DOM_DEF,
    parameter int CNT_W    = PG_CNT_W_DEF,
    parameter int HOLD_CYC = PG_HOLD_CYC_DEF,
    parameter int TMO_CYC  = PG_TMO_CYC_DEF
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [N_DOM-1:0] en,
    input  logic [N_DOM-1:0] sw_ack,
    input  logic [CNT_W-1:0] reference_count,
    input  logic [N_DOM-1:0] err_clr,
    output logic [N_DOM-1:0] status,
    output logic [N_DOM-1:0] en_iso,
    output logic [N_DOM-1:0] rtn,
    output logic [N_DOM-1:0] en_pw_sw,
    output logic [N_DOM-1:0] en_cg,
    output logic [N_DOM-1:0] busy,
    output logic [N_DOM-1:0] err
);

    for (genvar g = 0; g < N_DOM; g++) begin : g_dom
        pg_domain_fsm #(
            .CNT_W    (CNT_W),
            .HOLD_CYC (HOLD_CYC),
            .TMO_CYC  (TMO_CYC)
        ) u_fsm (
            .ck                (ck),
            .rst               (rst),
            .i_en              (en[g]),
            .i_sw_ack          (sw_ack[g]),
            .i_reference_count (reference_count),
            .i_err_clr         (err_clr[g]),
            .o_status          (status[g]),
            .o_en_iso          (en_iso[g]),
            .o_rtn             (rtn[g]),
            .o_en_pw_sw        (en_pw_sw[g]),
            .o_en_cg           (en_cg[g]),
            .o_busy            (busy[g]),
            .o_err             (err[g])
        );
    end

endmodule

// File: tb/tb_pg_multi_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pg_multi_ctrl
// Self-checking bench for pg_multi_ctrl (N_DOM=2, HOLD_CYC=2, TMO_CYC=8).
// Reference model: each domain walks a ring of 14 phases; every phase has a
// leave condition, leaving goes to the next phase on the ring, and the two
// early aborts jump across. Outputs come from phase ranges along the ring.
// A switch "plant" echoes en_pw_sw back on sw_ack after a configurable delay.
// -----------------------------------------------------------------------------
module tb_pg_multi_ctrl;

    localparam int N_DOM    = 2;
    localparam int CNT_W    = 18;
    localparam int HOLD_CYC = 2;
    localparam int TMO_CYC  = 8;
    localparam int MAXC     = (1 << CNT_W) - 1;
`ifdef PG_ACK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // Ring positions, in the order a domain visits them.
    localparam int P_IDLE_ON = 0, P_ISO_ON = 1, P_CG_ON = 2, P_SAVE = 3,
                   P_SW_OFF = 4, P_WAIT_OFF_ACK = 5, P_WAIT_OFF_CNT = 6,
                   P_IDLE_OFF = 7, P_SW_ON = 8, P_WAIT_ON_ACK = 9,
                   P_WAIT_ON_CNT = 10, P_RESTORE = 11, P_CG_OFF = 12,
                   P_ISO_OFF = 13, N_PH = 14;

    // {status, en_iso, rtn, en_pw_sw, en_cg, busy, err}
    localparam logic [6:0] RST_VEC    = 7'b1001100;
    localparam logic [6:0] CG_OFF_VEC = 7'b1101110;
    localparam logic [6:0] ISO_OFF_VEC = 7'b1001110;

    logic             ck = 1'b0;
    logic             rst;
    logic [N_DOM-1:0] en, sw_ack, err_clr;
    logic [CNT_W-1:0] reference_count;
    logic [N_DOM-1:0] status, en_iso, rtn, en_pw_sw, en_cg, busy, err;

    always #5 ck = ~ck;

    pg_multi_ctrl #(
        .N_DOM(N_DOM), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .ck(ck), .rst(rst), .en(en), .sw_ack(sw_ack),
        .reference_count(reference_count), .err_clr(err_clr),
        .status(status), .en_iso(en_iso), .rtn(rtn), .en_pw_sw(en_pw_sw),
        .en_cg(en_cg), .busy(busy), .err(err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_ph [N_DOM];
    int m_tm [N_DOM];
    bit m_er [N_DOM];

    // Switch plant.
    bit         plant_on;
    int         ack_dly [N_DOM];
    logic [7:0] pw_hist [N_DOM];

    function automatic void model_reset();
        for (int d = 0; d < N_DOM; d++) begin
            m_ph[d] = P_IDLE_ON;
            m_tm[d] = 0;
            m_er[d] = 1'b0;
        end
    endfunction

    // One clock edge of the model, using the inputs present before the edge.
    function automatic void model_step();
        for (int d = 0; d < N_DOM; d++) begin
            int p    = m_ph[d];
            int dest = (p + 1) % N_PH;
            bit leave = 1'b0;
            bit tmo   = 1'b0;
            if (p == P_ISO_ON || p == P_CG_ON || p == P_SAVE ||
                p == P_RESTORE || p == P_CG_OFF || p == P_ISO_OFF)
                leave = (m_tm[d] == HOLD_CYC);
            else if (p == P_SW_OFF || p == P_SW_ON)
                leave = 1'b1;
            else if (p == P_IDLE_ON)
                leave = !en[d];
            else if (p == P_IDLE_OFF)
                leave = en[d];
            else if (p == P_WAIT_OFF_CNT || p == P_WAIT_ON_CNT)
                leave = (m_tm[d] == int'(reference_count));
            else if (p == P_WAIT_OFF_ACK || p == P_WAIT_ON_ACK) begin
                leave = (p == P_WAIT_OFF_ACK) ? !sw_ack[d] : sw_ack[d];
                if (!leave && TMO_EN && m_tm[d] == TMO_CYC - 1) begin
                    leave = 1'b1;
                    tmo   = 1'b1;
                end
            end
            if (en[d] && p == P_ISO_ON) begin leave = 1'b1; dest = P_ISO_OFF; end
            if (en[d] && p == P_CG_ON)  begin leave = 1'b1; dest = P_CG_OFF;  end
            if (leave) begin
                m_ph[d] = dest;
                m_tm[d] = 0;
            end else if (m_tm[d] < MAXC) begin
                m_tm[d] = m_tm[d] + 1;
            end
            if (tmo)             m_er[d] = 1'b1;
            else if (err_clr[d]) m_er[d] = 1'b0;
        end
    endfunction

    function automatic logic [6:0] m_outs(input int d);
        int p = m_ph[d];
        return {!(p >= P_IDLE_OFF && p <= P_RESTORE),
                (p >= P_ISO_ON && p <= P_CG_OFF),
                (p >= P_SAVE && p <= P_WAIT_ON_CNT),
                !(p >= P_SW_OFF && p <= P_IDLE_OFF),
                !(p >= P_CG_ON && p <= P_RESTORE),
                !(p == P_IDLE_ON || p == P_IDLE_OFF),
                TMO_EN ? m_er[d] : 1'b0};
    endfunction

    function automatic logic [6:0] dut_outs(input int d);
        return {status[d], en_iso[d], rtn[d], en_pw_sw[d], en_cg[d], busy[d], err[d]};
    endfunction

    // Advance one clock; returns at the following falling edge.
    task automatic tick();
        if (rst) model_reset();
        else     model_step();
        @(posedge ck);
        @(negedge ck);
        for (int d = 0; d < N_DOM; d++) begin
            pw_hist[d] = {pw_hist[d][6:0], en_pw_sw[d]};
            if (plant_on) sw_ack[d] = pw_hist[d][ack_dly[d]-1];
        end
    endtask

    task automatic apply_reset();
        rst             = 1'b1;
        en              = '1;
        sw_ack          = '1;
        err_clr         = '0;
        reference_count = CNT_W'(3);
        plant_on        = 1'b0;
        for (int d = 0; d < N_DOM; d++) begin
            pw_hist[d] = '1;
            ack_dly[d] = 2;
        end
        model_reset();
        @(negedge ck);
        @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = '1;
        @(negedge ck);
        for (int d = 0; d < N_DOM; d++) begin
            total++;
            if (dut_outs(d) !== RST_VEC) begin
                bad++;
                $display("FAIL reset_held dom%0d: got %b want %b", d, dut_outs(d), RST_VEC);
            end
        end
        apply_reset();
        repeat (3) tick();
        for (int d = 0; d < N_DOM; d++) begin
            total++;
            if (dut_outs(d) !== RST_VEC) begin
                bad++;
                $display("FAIL reset_idle dom%0d: got %b want %b", d, dut_outs(d), RST_VEC);
            end
        end
    endtask

    // Power-down of domain 0 with the switch echoing after 2 cycles, ref=3.
    task automatic test_power_down();
        int  t_iso = -1, t_cg = -1;
        bit  done  = 1'b0;
        apply_reset();
        plant_on = 1'b1;
        en[0]    = 1'b0;
        for (int c = 1; c <= 80 && !done; c++) begin
            tick();
            total++;
            if (dut_outs(0) !== m_outs(0)) begin
                bad++;
                $display("FAIL pd_model cyc%0d: got %b want %b", c, dut_outs(0), m_outs(0));
            end
            total++;
            if (dut_outs(1) !== RST_VEC) begin
                bad++;
                $display("FAIL pd_dom1_steady cyc%0d: got %b want %b", c, dut_outs(1), RST_VEC);
            end
            if (en_iso[0] && t_iso < 0) t_iso = c;
            if (!en_cg[0] && t_cg < 0)  t_cg  = c;
            if (!busy[0] && !status[0]) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL pd_reach_idle_off: got timeout want IDLE_OFF");
        end
        total++;
        if ({status[0], rtn[0], en_pw_sw[0]} !== 3'b010) begin
            bad++;
            $display("FAIL pd_idle_off_outs: got %b want 010", {status[0], rtn[0], en_pw_sw[0]});
        end
        total++;
        if (t_cg - t_iso != HOLD_CYC + 1) begin
            bad++;
            $display("FAIL pd_cg_after_iso: got %0d want %0d", t_cg - t_iso, HOLD_CYC + 1);
        end
    endtask

    // Wake domain 0 from IDLE_OFF (left there by test_power_down).
    task automatic test_wake();
        int t_ack = -1, t_rtn = -1, t_cg = -1;
        bit done  = 1'b0;
        en[0] = 1'b1;
        for (int c = 1; c <= 80 && !done; c++) begin
            tick();
            total++;
            if (dut_outs(0) !== m_outs(0)) begin
                bad++;
                $display("FAIL wk_model cyc%0d: got %b want %b", c, dut_outs(0), m_outs(0));
            end
            if (sw_ack[0] && t_ack < 0)          t_ack = c;
            if (!rtn[0] && t_rtn < 0)            t_rtn = c;
            if (en_cg[0] && t_rtn >= 0 && t_cg < 0) t_cg = c;
            if (!busy[0] && status[0])           done = 1'b1;
        end
        // ack is sampled on the next edge, then 4 counting cycles (ref=3).
        total++;
        if (t_rtn - t_ack != 5) begin
            bad++;
            $display("FAIL wk_restore_delay: got %0d want 5", t_rtn - t_ack);
        end
        total++;
        if (t_cg - t_rtn != HOLD_CYC + 1) begin
            bad++;
            $display("FAIL wk_rtn_before_cg: got %0d want %0d", t_cg - t_rtn, HOLD_CYC + 1);
        end
        total++;
        if (!done || dut_outs(0) !== RST_VEC) begin
            bad++;
            $display("FAIL wk_idle_on: got %b want %b", dut_outs(0), RST_VEC);
        end
    endtask

    // Aborts from ISO_ON and from CG_ON.
    task automatic test_abort();
        bit saw_rtn = 1'b0, saw_off = 1'b0, saw_iso_off = 1'b0, done = 1'b0;
        apply_reset();
        plant_on = 1'b1;
        en[0] = 1'b0;
        tick();
        en[0] = 1'b1;
        tick();
        total++;
        if (dut_outs(0) !== ISO_OFF_VEC) begin
            bad++;
            $display("FAIL ab_iso_to_iso_off: got %b want %b", dut_outs(0), ISO_OFF_VEC);
        end
        repeat (HOLD_CYC + 1) tick();
        total++;
        if (dut_outs(0) !== RST_VEC) begin
            bad++;
            $display("FAIL ab_iso_back_idle: got %b want %b", dut_outs(0), RST_VEC);
        end
        en[0] = 1'b0;
        for (int c = 0; c < 20 && en_cg[0]; c++) tick();
        en[0] = 1'b1;
        tick();
        total++;
        if (dut_outs(0) !== CG_OFF_VEC) begin
            bad++;
            $display("FAIL ab_cg_to_cg_off: got %b want %b", dut_outs(0), CG_OFF_VEC);
        end
        for (int c = 1; c <= 20 && !done; c++) begin
            tick();
            total++;
            if (dut_outs(0) !== m_outs(0)) begin
                bad++;
                $display("FAIL ab_model cyc%0d: got %b want %b", c, dut_outs(0), m_outs(0));
            end
            saw_rtn     |= rtn[0];
            saw_off     |= !en_pw_sw[0];
            saw_iso_off |= (!en_iso[0] && busy[0]);
            if (!busy[0]) done = 1'b1;
        end
        total++;
        if (!done || saw_rtn || saw_off || !saw_iso_off) begin
            bad++;
            $display("FAIL ab_cg_sequence: got done=%0b rtn=%0b off=%0b iso_off=%0b want 1 0 0 1",
                     done, saw_rtn, saw_off, saw_iso_off);
        end
    endtask

    // Switch ack stuck closed during power-down. Domain 1 holds err_clr high.
    task automatic test_timeout();
        bit done = 1'b0;
        apply_reset();
        en      = '0;
        err_clr = 2'b10;
        for (int c = 0; c < 20 && en_pw_sw[0]; c++) tick();
        repeat (TMO_CYC) tick();
        total++;
        if (err !== 2'b00 || en_pw_sw[0] !== 1'b0) begin
            bad++;
            $display("FAIL to_before_limit: got err=%b pw=%b want 00 0", err, en_pw_sw[0]);
        end
        tick();
`ifdef PG_ACK_TIMEOUT_EN
        total++;
        if (err !== 2'b11) begin
            bad++;
            $display("FAIL to_err_set: got %b want 11", err);
        end
        tick();
        total++;
        if (err !== 2'b01) begin
            bad++;
            $display("FAIL to_clr_after_set: got %b want 01", err);
        end
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (!busy[0]) done = 1'b1;
        end
        total++;
        if (!done || dut_outs(0) !== m_outs(0) || err[0] !== 1'b1) begin
            bad++;
            $display("FAIL to_idle_off: got %b want %b", dut_outs(0), m_outs(0));
        end
        err_clr = 2'b01;
        tick();
        err_clr = 2'b00;
        total++;
        if (err !== 2'b00) begin
            bad++;
            $display("FAIL to_err_clr: got %b want 00", err);
        end
`else
        repeat (40) tick();
        total++;
        if (err !== 2'b00 || busy[0] !== 1'b1 || en_pw_sw[0] !== 1'b0) begin
            bad++;
            $display("FAIL to_wait_forever: got err=%b busy=%b pw=%b want 00 1 0",
                     err, busy[0], en_pw_sw[0]);
        end
        sw_ack = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (!busy[0]) done = 1'b1;
        end
        total++;
        if (!done || dut_outs(0) !== m_outs(0)) begin
            bad++;
            $display("FAIL to_idle_off: got %b want %b", dut_outs(0), m_outs(0));
        end
`endif
    endtask

    // Domain 1 stays on while domain 0 cycles; async reset from WAIT_ON_CNT.
    task automatic test_indep_reset();
        bit reached = 1'b0;
        apply_reset();
        plant_on        = 1'b1;
        reference_count = CNT_W'(5);
        en[0]           = 1'b0;
        for (int c = 0; c < 80 && !(status[0] == 1'b0 && busy[0] == 1'b0); c++) tick();
        en[0] = 1'b1;
        for (int c = 0; c < 40 && !reached; c++) begin
            tick();
            if (m_ph[0] == P_WAIT_ON_CNT) reached = 1'b1;
        end
        total++;
        if (!reached || dut_outs(0) !== m_outs(0) || dut_outs(1) !== RST_VEC) begin
            bad++;
            $display("FAIL ir_wait_on_cnt: got %b/%b want %b/%b",
                     dut_outs(0), dut_outs(1), m_outs(0), RST_VEC);
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < N_DOM; d++) begin
            total++;
            if (dut_outs(d) !== RST_VEC) begin
                bad++;
                $display("FAIL ir_async_reset dom%0d: got %b want %b", d, dut_outs(d), RST_VEC);
            end
        end
        model_reset();
        @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        plant_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0)
                for (int d = 0; d < N_DOM; d++) ack_dly[d] = $urandom_range(1, 4);
            if ($urandom_range(0, 29) == 0) reference_count = CNT_W'($urandom_range(0, 6));
            for (int d = 0; d < N_DOM; d++) begin
                if ($urandom_range(0, 9) == 0) en[d] = ~en[d];
                err_clr[d] = ($urandom_range(0, 7) == 0);
            end
            tick();
            for (int d = 0; d < N_DOM; d++) begin
                total++;
                if (dut_outs(d) !== m_outs(d)) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL rnd cyc%0d dom%0d: got %b want %b phase %0d",
                                 c, d, dut_outs(d), m_outs(d), m_ph[d]);
                end
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        en              = '1;
        sw_ack          = '1;
        err_clr         = '0;
        reference_count = CNT_W'(3);
        plant_on        = 1'b0;
        for (int d = 0; d < N_DOM; d++) begin
            pw_hist[d] = '1;
            ack_dly[d] = 2;
        end
        model_reset();
        test_reset();
        test_power_down();
        test_wake();
        test_abort();
        test_timeout();
        test_indep_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
